// File: rtl/bitpair_pkg.sv
// Shared types and defaults for the bit-pair deserializer.
package bitpair_pkg;

  localparam int PAIRS_DEF  = 4;
  localparam int DROP_W_DEF = 8;

  typedef logic [1:0] pair_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_LAST  = 2'd2
  } fill_st_e;

  function automatic pair_t pack_pair(input logic y, input logic z);
    return {y, z};
  endfunction

endpackage

// File: rtl/bitpair_out_reg.sv
// Output word holding register with valid/ready handshake.
// Optional parity output when BITPAIR_PARITY_EN is defined.
module bitpair_out_reg
  import bitpair_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
`ifdef BITPAIR_PARITY_EN
  output logic         o_par,
`endif
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
`ifdef BITPAIR_PARITY_EN
  logic         r_par;
`endif

  // A load can only arrive when the held word is leaving or absent, so the
  // hold rule never has to arbitrate against a load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef BITPAIR_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
`ifdef BITPAIR_PARITY_EN
      r_par   <= ^i_data;
`endif
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
`ifdef BITPAIR_PARITY_EN
  assign o_par   = r_par;
`endif

endmodule

// File: rtl/bitpair_deserializer.sv
// Packs PAIRS {y,z} bit pairs into one word with resync and a saturating drop counter.
// Define BITPAIR_PARITY_EN to add the registered o_out_par output.
//
// state    | meaning
// ST_EMPTY | no pairs held, next accept is pair 0
// ST_FILL  | 0 < cnt < PAIRS-1, accumulating middle pairs
// ST_LAST  | cnt = PAIRS-1, next non-sync accept completes the word
module bitpair_deserializer
  import bitpair_pkg::*;
#(
  parameter int PAIRS  = PAIRS_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_in_valid,
  input  logic                i_in_y,
  input  logic                i_in_z,
  input  logic                i_in_sync,
  output logic                o_in_ready,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [2*PAIRS-1:0]  o_out_data,
`ifdef BITPAIR_PARITY_EN
  output logic                o_out_par,
`endif
  output logic [DROP_W-1:0]   o_drop_cnt
);

  localparam int W  = 2 * PAIRS;
  localparam int CW = $clog2(PAIRS);
  localparam fill_st_e ST_AFTER0 = (PAIRS == 2) ? ST_LAST : ST_FILL;

  fill_st_e          r_state;
  logic [CW-1:0]     r_cnt;
  logic [W-3:0]      r_shift;
  logic [DROP_W-1:0] r_drop;

  pair_t             w_pair;
  logic              w_accept;
  logic              w_resync;
  logic              w_load;
  logic              w_out_valid;
  logic [W-1:0]      w_word;

  assign w_pair     = pack_pair(i_in_y, i_in_z);
  // Only the completing pair stalls; earlier pairs fill while a word is held.
  assign o_in_ready = !(r_state == ST_LAST && w_out_valid && !i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_resync   = w_accept & i_in_sync & (r_state != ST_EMPTY);
  assign w_load     = w_accept & !w_resync & (r_state == ST_LAST);
  assign w_word     = {w_pair, r_shift};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_shift <= '0;
      r_drop  <= '0;
    end else if (w_accept) begin
      if (w_resync) begin
        r_shift[1:0] <= w_pair;
        r_cnt        <= CW'(1);
        r_state      <= ST_AFTER0;
        if (r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      end else begin
        case (r_state)
          ST_EMPTY: begin
            r_shift[1:0] <= w_pair;
            r_cnt        <= CW'(1);
            r_state      <= ST_AFTER0;
          end
          ST_FILL: begin
            r_shift[{r_cnt, 1'b0} +: 2] <= w_pair;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(PAIRS - 2)) r_state <= ST_LAST;
          end
          ST_LAST: begin
            r_cnt   <= '0;
            r_state <= ST_EMPTY;
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_EMPTY;
          end
        endcase
      end
    end
  end

  bitpair_out_reg #(.W(W)) u_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_data  (w_word),
    .i_ready (i_out_ready),
    .o_valid (w_out_valid),
`ifdef BITPAIR_PARITY_EN
    .o_par   (o_out_par),
`endif
    .o_data  (o_out_data)
  );

  assign o_out_valid = w_out_valid;
  assign o_drop_cnt  = r_drop;

endmodule
